// File: rtl/rr_merge2_nbit.sv
// rtl/rr_merge2_nbit.sv - packet-aware two-input round-robin merge with registered output stage
module rr_merge2_nbit #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a_data,
    input  logic         a_valid,
    input  logic         a_last,
    output logic         a_ready,
    input  logic [N-1:0] b_data,
    input  logic         b_valid,
    input  logic         b_last,
    output logic         b_ready,
    output logic         sel,
    output logic [N-1:0] f_data,
    output logic         f_valid,
    output logic         f_last,
    input  logic         f_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         prio_q, prio_d;
    logic [N-1:0] f_data_q, f_data_d;
    logic         f_valid_q, f_valid_d;
    logic         f_last_q, f_last_d;

    logic         sel_w;
    logic         load_en;
    logic         acc;
    logic         sel_last;
    logic [N-1:0] sel_data;

    // Output stage can take a beat when empty or when its current beat is leaving.
    assign load_en  = ~f_valid_q | f_ready;
    assign acc      = (sel_w ? a_valid : b_valid) & load_en;
    assign sel_last = sel_w ? a_last : b_last;
    assign sel_data = sel_w ? a_data : b_data;

    // Grant: a locked packet owns the mux; otherwise a lone requester wins, ties go to prio.
    always_comb begin
        sel_w = prio_q;
        case (state_q)
            LOCK_A:  sel_w = 1'b1;
            LOCK_B:  sel_w = 1'b0;
            default: begin
                if (a_valid & ~b_valid) begin
                    sel_w = 1'b1;
                end else if (b_valid & ~a_valid) begin
                    sel_w = 1'b0;
                end else begin
                    sel_w = prio_q;
                end
            end
        endcase
    end

    assign sel     = sel_w;
    assign a_ready = load_en & sel_w;
    assign b_ready = load_en & ~sel_w;
    assign f_data  = f_data_q;
    assign f_valid = f_valid_q;
    assign f_last  = f_last_q;

    // Next state: hold the grant across a packet; hand priority to the other side after a last beat.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        if (acc) begin
            if (sel_last) begin
                state_d = IDLE;
                prio_d  = ~sel_w;
            end else begin
                state_d = sel_w ? LOCK_A : LOCK_B;
            end
        end
    end

    // Output register: load on accept, empty out when drained with nothing new arriving.
    always_comb begin
        f_data_d  = f_data_q;
        f_valid_d = f_valid_q;
        f_last_d  = f_last_q;
        if (acc) begin
            f_data_d  = sel_data;
            f_last_d  = sel_last;
            f_valid_d = 1'b1;
        end else if (f_ready) begin
            f_valid_d = 1'b0;
        end
    end

    // Arbitration state register; reset abandons any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prio_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

    // Output stage register; reset drops whatever beat was held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_data_q  <= '0;
            f_valid_q <= 1'b0;
            f_last_q  <= 1'b0;
        end else begin
            f_data_q  <= f_data_d;
            f_valid_q <= f_valid_d;
            f_last_q  <= f_last_d;
        end
    end

endmodule

// File: tb/tb_rr_merge2_nbit.sv
// tb/tb_rr_merge2_nbit.sv - self-checking bench for rr_merge2_nbit against a packet-level reference model
module tb_rr_merge2_nbit;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] a_data, b_data, f_data;
    logic         a_valid, a_last, a_ready;
    logic         b_valid, b_last, b_ready;
    logic         sel, f_valid, f_last, f_ready;

    int vectors = 0;
    int miscompares = 0;

    // reference model: packet owner (0 none, 1 A, 2 B), priority side, output register contents
    int           owner;
    bit           m_prio;
    bit           m_fv;
    bit           m_fl;
    logic [N-1:0] m_fd;

    rr_merge2_nbit #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_data(a_data), .a_valid(a_valid), .a_last(a_last), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_last(b_last), .b_ready(b_ready),
        .sel(sel), .f_data(f_data), .f_valid(f_valid), .f_last(f_last), .f_ready(f_ready)
    );

    always #5 clk = ~clk;

    function automatic bit m_sel();
        if (owner == 1) return 1'b1;
        if (owner == 2) return 1'b0;
        if (a_valid && !b_valid) return 1'b1;
        if (b_valid && !a_valid) return 1'b0;
        return m_prio;
    endfunction

    task automatic model_reset();
        owner  = 0;
        m_prio = 1'b1;
        m_fv   = 1'b0;
        m_fl   = 1'b0;
        m_fd   = '0;
    endtask

    // advance one clock, applying the transfer rules to the model
    task automatic tick(output bit acc_a, output bit acc_b);
        bit s, ld, acc, lst;
        logic [N-1:0] d;
        s   = m_sel();
        ld  = !m_fv || f_ready;
        acc = ld && (s ? a_valid : b_valid);
        lst = s ? a_last : b_last;
        d   = s ? a_data : b_data;
        acc_a = acc && s;
        acc_b = acc && !s;
        @(posedge clk);
        if (acc) begin
            m_fv = 1'b1;
            m_fd = d;
            m_fl = lst;
            if (lst) begin
                owner  = 0;
                m_prio = !s;
            end else begin
                owner = s ? 1 : 2;
            end
        end else if (f_ready) begin
            m_fv = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        a_valid = 0; b_valid = 0; a_last = 0; b_last = 0;
        a_data = '0; b_data = '0; f_ready = 1;
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_reset();
        bit aa, ab;
        do_reset();
        b_valid = 1; b_data = 4'hD; b_last = 1; f_ready = 0;
        #2;
        tick(aa, ab);
        b_valid = 0;
        #2;
        vectors++;
        if (f_valid !== 1'b1) begin miscompares++; $display("FAIL reset_preload_valid: got %b expected 1", f_valid); end
        rst_n = 0;
        #1;
        vectors++;
        if (f_valid !== 1'b0) begin miscompares++; $display("FAIL reset_f_valid: got %b expected 0", f_valid); end
        vectors++;
        if (f_data !== 4'h0) begin miscompares++; $display("FAIL reset_f_data: got %h expected 0", f_data); end
        vectors++;
        if (f_last !== 1'b0) begin miscompares++; $display("FAIL reset_f_last: got %b expected 0", f_last); end
        vectors++;
        if (sel !== 1'b1) begin miscompares++; $display("FAIL reset_sel: got %b expected 1", sel); end
        vectors++;
        if (a_ready !== 1'b1) begin miscompares++; $display("FAIL reset_a_ready: got %b expected 1", a_ready); end
        vectors++;
        if (b_ready !== 1'b0) begin miscompares++; $display("FAIL reset_b_ready: got %b expected 0", b_ready); end
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_alternation();
        bit aa, ab;
        do_reset();
        a_valid = 1; a_last = 1; a_data = 4'h3;
        b_valid = 1; b_last = 1; b_data = 4'hC;
        f_ready = 1;
        for (int i = 0; i < 8; i++) begin
            #2;
            vectors++;
            if (sel !== (i % 2 == 0)) begin miscompares++; $display("FAIL alt_sel[%0d]: got %b expected %b", i, sel, (i % 2 == 0)); end
            if (i > 0) begin
                vectors++;
                if (f_valid !== 1'b1) begin miscompares++; $display("FAIL alt_f_valid[%0d]: got %b expected 1", i, f_valid); end
                vectors++;
                if (f_data !== ((i % 2 == 1) ? 4'h3 : 4'hC)) begin
                    miscompares++;
                    $display("FAIL alt_f_data[%0d]: got %h expected %h", i, f_data, ((i % 2 == 1) ? 4'h3 : 4'hC));
                end
            end
            tick(aa, ab);
        end
        a_valid = 0; b_valid = 0;
    endtask

    task automatic test_packet_lock();
        bit aa, ab;
        bit           av [7] = '{1, 1, 0, 1, 0, 0, 0};
        logic [N-1:0] ad [7] = '{4'h1, 4'h2, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0};
        bit           al [7] = '{0, 0, 0, 1, 0, 0, 0};
        logic [N-1:0] exp_q [4] = '{4'h1, 4'h2, 4'h3, 4'hF};
        logic [N-1:0] got_q [$];
        do_reset();
        b_valid = 1; b_data = 4'hF; b_last = 1; f_ready = 1;
        for (int i = 0; i < 7; i++) begin
            a_valid = av[i]; a_data = ad[i]; a_last = al[i];
            #2;
            if (f_valid && f_ready) got_q.push_back(f_data);
            if (i <= 3) begin
                vectors++;
                if (b_ready !== 1'b0) begin miscompares++; $display("FAIL lock_b_ready[%0d]: got %b expected 0", i, b_ready); end
            end
            tick(aa, ab);
            if (ab) b_valid = 0;
        end
        vectors++;
        if (got_q.size() != 4) begin
            miscompares++;
            $display("FAIL lock_count: got %0d expected 4", got_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (got_q[k] !== exp_q[k]) begin miscompares++; $display("FAIL lock_beat[%0d]: got %h expected %h", k, got_q[k], exp_q[k]); end
            end
        end
    endtask

    task automatic test_backpressure();
        bit aa, ab;
        do_reset();
        a_valid = 1; a_data = 4'h5; a_last = 1; f_ready = 0;
        #2;
        tick(aa, ab);
        a_valid = 0;
        b_valid = 1; b_data = 4'h9; b_last = 1;
        for (int i = 0; i < 4; i++) begin
            #2;
            vectors++;
            if (f_valid !== 1'b1) begin miscompares++; $display("FAIL bp_f_valid[%0d]: got %b expected 1", i, f_valid); end
            vectors++;
            if (f_data !== 4'h5) begin miscompares++; $display("FAIL bp_f_data[%0d]: got %h expected 5", i, f_data); end
            vectors++;
            if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_ready[%0d]: got a=%b b=%b expected a=0 b=0", i, a_ready, b_ready);
            end
            vectors++;
            if (sel !== 1'b0) begin miscompares++; $display("FAIL bp_sel[%0d]: got %b expected 0", i, sel); end
            tick(aa, ab);
        end
        f_ready = 1;
        #2;
        vectors++;
        if (b_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_b_ready: got %b expected 1", b_ready); end
        tick(aa, ab);
        b_valid = 0;
        #2;
        vectors++;
        if (f_valid !== 1'b1 || f_data !== 4'h9) begin
            miscompares++;
            $display("FAIL bp_next_beat: got v=%b d=%h expected v=1 d=9", f_valid, f_data);
        end
        tick(aa, ab);
    endtask

    task automatic test_single_requester();
        bit aa, ab;
        do_reset();
        b_valid = 1; b_data = 4'h6; b_last = 0; f_ready = 1;
        #2;
        vectors++;
        if (sel !== 1'b0 || b_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_first: got sel=%b b_ready=%b expected sel=0 b_ready=1", sel, b_ready);
        end
        tick(aa, ab);
        b_data = 4'h7; b_last = 1;
        #2;
        vectors++;
        if (sel !== 1'b0 || b_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_second: got sel=%b b_ready=%b expected sel=0 b_ready=1", sel, b_ready);
        end
        vectors++;
        if (f_data !== 4'h6) begin miscompares++; $display("FAIL single_data0: got %h expected 6", f_data); end
        tick(aa, ab);
        a_valid = 1; a_data = 4'h1; a_last = 1;
        b_valid = 1; b_data = 4'h8; b_last = 1;
        #2;
        vectors++;
        if (sel !== 1'b1) begin miscompares++; $display("FAIL single_prio_after: got %b expected 1", sel); end
        vectors++;
        if (f_data !== 4'h7 || f_last !== 1'b1) begin
            miscompares++;
            $display("FAIL single_data1: got d=%h l=%b expected d=7 l=1", f_data, f_last);
        end
        tick(aa, ab);
        a_valid = 0; b_valid = 0;
    endtask

    task automatic test_mid_reset();
        bit aa, ab;
        do_reset();
        b_valid = 1; b_data = 4'h1; b_last = 0; f_ready = 1;
        #2;
        tick(aa, ab);
        b_data = 4'h2;
        #2;
        vectors++;
        if (b_ready !== 1'b1) begin miscompares++; $display("FAIL mid_b_ready: got %b expected 1", b_ready); end
        rst_n = 0;
        #1;
        vectors++;
        if (f_valid !== 1'b0) begin miscompares++; $display("FAIL mid_f_valid: got %b expected 0", f_valid); end
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        a_valid = 1; a_data = 4'hA; a_last = 1;
        b_valid = 1; b_data = 4'hE; b_last = 0;
        #2;
        vectors++;
        if (sel !== 1'b1) begin miscompares++; $display("FAIL mid_idle_sel: got %b expected 1", sel); end
        tick(aa, ab);
        a_valid = 0; b_valid = 0;
        #2;
        vectors++;
        if (f_valid !== 1'b1 || f_data !== 4'hA || f_last !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_new_beat: got v=%b d=%h l=%b expected v=1 d=a l=1", f_valid, f_data, f_last);
        end
        tick(aa, ab);
    endtask

    task automatic test_random();
        bit aa, ab, s, ld;
        int a_rem, b_rem;
        do_reset();
        a_rem = 0; b_rem = 0;
        for (int i = 0; i < 600; i++) begin
            if (!a_valid && $urandom_range(0, 3) != 0) begin
                if (a_rem == 0) a_rem = $urandom_range(1, 4);
                a_data = N'($urandom);
                a_last = (a_rem == 1);
                a_valid = 1;
            end
            if (!b_valid && $urandom_range(0, 3) != 0) begin
                if (b_rem == 0) b_rem = $urandom_range(1, 4);
                b_data = N'($urandom);
                b_last = (b_rem == 1);
                b_valid = 1;
            end
            f_ready = ($urandom_range(0, 3) != 0);
            #2;
            s  = m_sel();
            ld = !m_fv || f_ready;
            vectors++;
            if (sel !== s) begin miscompares++; $display("FAIL rnd_sel[%0d]: got %b expected %b", i, sel, s); end
            vectors++;
            if (a_ready !== (ld && s) || b_ready !== (ld && !s)) begin
                miscompares++;
                $display("FAIL rnd_ready[%0d]: got a=%b b=%b expected a=%b b=%b", i, a_ready, b_ready, ld && s, ld && !s);
            end
            vectors++;
            if (f_valid !== m_fv) begin miscompares++; $display("FAIL rnd_f_valid[%0d]: got %b expected %b", i, f_valid, m_fv); end
            if (m_fv) begin
                vectors++;
                if (f_data !== m_fd || f_last !== m_fl) begin
                    miscompares++;
                    $display("FAIL rnd_f_beat[%0d]: got d=%h l=%b expected d=%h l=%b", i, f_data, f_last, m_fd, m_fl);
                end
            end
            tick(aa, ab);
            if (aa) begin a_rem--; a_valid = 0; end
            if (ab) begin b_rem--; b_valid = 0; end
        end
        a_valid = 0; b_valid = 0;
    endtask

    initial begin
        rst_n = 0;
        a_valid = 0; b_valid = 0; a_last = 0; b_last = 0;
        a_data = '0; b_data = '0; f_ready = 1;
        model_reset();
        test_reset();
        test_alternation();
        test_packet_lock();
        test_backpressure();
        test_single_requester();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_merge2_nbit.md
# rr_merge2_nbit

Two-input, packet-aware round-robin merge that sits directly upstream of `mux2x1_nbit` in the datapath. It arbitrates between two valid/ready N-bit streams (A and B). It drives the mux `sel` line and registers the selected beat into a one-entry output stage. A multi-beat packet is never interleaved: once a packet starts on one input, that input keeps the grant until its `last` beat is accepted.

## Interface
- `N`, default 4: data width of both inputs and the output.

- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `a_data`  input  N  stream A payload.
- `a_valid`  input  1  stream A beat present.
- `a_last`  input  1  final beat of the stream A packet.
- `a_ready`  output  1  stream A beat accepted this cycle.
- `b_data`  input  N  stream B payload.
- `b_valid`  input  1  stream B beat present.
- `b_last`  input  1  final beat of the stream B packet.
- `b_ready`  output  1  stream B beat accepted this cycle.
- `sel`  output  1  current grant (1 = A, 0 = B). Same polarity as the downstream mux (`f = sel ? a : b`).
- `f_data`  output  N  registered merged payload.
- `f_valid`  output  1  output beat present.
- `f_last`  output  1  registered last flag.
- `f_ready`  input  1  downstream accepts the output beat.

## Operation
- State registers:
  - FSM: `IDLE`, `LOCK_A`, `LOCK_B`.
  - `prio`: 1 = A has priority, 0 = B has priority.
  - Output stage: `f_data`, `f_valid`, `f_last`.
- `load_en = ~f_valid | f_ready`. The output register accepts a new beat whenever it is empty or currently draining.
- `sel` is combinational:
  - `LOCK_A` → 1; `LOCK_B` → 0.
  - `IDLE`, only `a_valid` → 1; only `b_valid` → 0.
  - `IDLE`, both valid or neither valid → `prio`.
- `a_ready = load_en & sel`; `b_ready = load_en & ~sel`.
- Accept condition: `acc = (sel ? a_valid : b_valid) & load_en`.
- On `acc`:
  - Load `f_data` and `f_last` from the selected input.
  - Set `f_valid = 1`.
- If there is no `acc` but `f_ready` is high, clear `f_valid`. `f_data` and `f_last` hold their values.
- FSM transitions, taken only on `acc`:
  - `IDLE`, `last = 0` → `LOCK_A` or `LOCK_B` (the granted side).
  - `IDLE`, `last = 1` → stay in `IDLE`, toggle `prio` to the non-granted side.
  - `LOCK_X`, `last = 0` → stay in `LOCK_X`.
  - `LOCK_X`, `last = 1` → `IDLE`, set `prio` to the other side.
- While in `LOCK_X`, the other input is stalled (ready = 0) even if the locked input is idle (valid low).
- Reset values:
  - FSM = `IDLE`, `prio = 1`.
  - `f_valid = 0`, `f_data = 0`, `f_last = 0`.
  - `sel = 1`, `a_ready = 1`, `b_ready = 0`.
- Reset asserted mid-packet: all state is cleared immediately (asynchronously). Any partial packet is abandoned, and the beat held in the output register is dropped.

## Timing
- A transfer occurs on the rising edge where valid & ready are both high, on any port.
- Upstream: once `x_valid` rises, `x_data` and `x_last` stay stable until the beat is accepted.
- Output: `f_valid`, `f_data` and `f_last` stay stable until `f_ready` is high.
- Latency is 1 cycle: a beat accepted at edge k appears on `f_*` after edge k.
- Throughput is 1 beat per cycle with `f_ready` held high. There are no bubbles at grant switches.
- `f_ready` low with `f_valid` high: both input readys are 0, and `sel` and the FSM hold.
- `f_ready` combinationally affects `a_ready` and `b_ready` (through `load_en`). No other comb paths exist from inputs to outputs, except valid → `sel` → ready while in `IDLE`.
- `sel` changes only in `IDLE` (following valids and `prio`) or after an edge that changes the FSM state.

## Test plan
- **Reset:** assert `rst_n = 0` mid-cycle → `f_valid = 0`, `f_data = 0`, `sel = 1`, `a_ready = 1`, `b_ready = 0` immediately, without waiting for a clock.
- **Alternation:** hold `a_valid` and `b_valid` high with single-beat packets (`last = 1`), payloads A = 4'h3 and B = 4'hC, `f_ready` held high → `f_data` sequence 3, C, 3, C…, `sel` toggling every cycle, `f_valid` continuously 1.
- **Packet lock:** A sends a 3-beat packet 1, 2, 3 (last on 3) while `b_valid` is held with 4'hF → output 1, 2, 3, F, with `b_ready = 0` for the whole A packet even if A inserts one idle cycle.
- **Backpressure:** `f_ready = 0` for 4 cycles while `f_valid = 1` holding 4'h5 → `f_data` stays 5, both readys are 0, no input beat is lost. After `f_ready` returns to 1, the next granted beat appears one cycle later.
- **Single requester:** only `b_valid` with `prio = 1` → `sel = 0`, B is accepted with no wait cycle, and `prio` becomes 1 after B's last beat.
- **Mid-packet reset:** assert reset on beat 2 of a 4-beat B packet → FSM returns to `IDLE`. After release, a new A single-beat packet passes with no residual B data.
